// File: rtl/pipe_pkg.sv
// Shared types for CPU pipeline-stage registers: occupancy states and the
// stage control bundle whose all-zero encoding is the NOP bubble.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic        reg_wr;
    logic        mem_wr;
    logic        mem_rd;
    logic        mem_to_reg;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        ext_op;
    logic [3:0]  alu_ctr;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [2:0]  mem_size;
    logic [17:0] rsvd;
  } stage_ctrl_t;

  // Zero encoding: no register write, no memory access, no branch.
  localparam stage_ctrl_t STAGE_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Event counter that sticks at all-ones; cleared only by reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) count <= '0;
    else if (inc) count <= sat_inc(count);
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry,
// flush-to-bubble on the control field and stall/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 128,
  parameter int                 CTRL_W   = 48,
  parameter logic [CTRL_W-1:0]  CTRL_RST = CTRL_W'(STAGE_CTRL_NOP),
  parameter bit                 SKID     = 1'b1,
  parameter int                 CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e       state, state_n;
  logic              rdy_q;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              push, pop;

  // Without a skid entry the stage can only accept when its beat leaves now.
  assign in_ready = SKID ? rdy_q : (!out_valid || out_ready);
  assign pop      = out_valid && out_ready;
  assign push     = in_valid && in_ready && !flush;

  always_comb begin
    state_n = state;
    case (state)
      ST_EMPTY: if (push) state_n = ST_FULL;
      ST_FULL: begin
        if (push && !pop)      state_n = SKID ? ST_SKID : ST_FULL;
        else if (!push && pop) state_n = ST_EMPTY;
      end
      ST_SKID:  if (pop) state_n = ST_FULL;
      default:  state_n = ST_EMPTY;
    endcase
    if (flush) state_n = ST_EMPTY;
  end

  // Stage boundary: main entry drives out_*, skid entry backs it up.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      rdy_q     <= 1'b1;
      out_ctrl  <= CTRL_RST;
      out_data  <= '0;
      skid_ctrl <= CTRL_RST;
      skid_data <= '0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n != ST_EMPTY);
      rdy_q     <= (state_n != ST_SKID);
      if (flush) begin
        out_ctrl  <= CTRL_RST;
        skid_ctrl <= CTRL_RST;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (push) begin
              out_ctrl <= in_ctrl;
              out_data <= in_data;
            end
          end
          ST_FULL: begin
            if (push && pop) begin
              out_ctrl <= in_ctrl;
              out_data <= in_data;
            end else if (push) begin
              skid_ctrl <= in_ctrl;
              skid_data <= in_data;
            end else if (pop) begin
              out_ctrl <= CTRL_RST;
            end
          end
          ST_SKID: begin
            if (pop) begin
              out_ctrl  <= skid_ctrl;
              out_data  <= skid_data;
              skid_ctrl <= CTRL_RST;
            end
          end
          default: ;
        endcase
      end
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (flush && (out_valid || state == ST_SKID)),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 stage (4-bit counters) and a SKID=0
// stage share stimulus and are compared against a FIFO-occupancy model.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;

  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [3:0]    a_stall, a_bubble;

  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [15:0]   b_stall, b_bubble;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST('0), .SKID(1'b1), .CNT_W(4)) u_a (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST('0), .SKID(1'b0), .CNT_W(16)) u_b (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
  );

  always #5 Clk = ~Clk;

  // Reference: each stage is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         mq    [2][2];
  int            msz   [2];
  logic [DW-1:0] mlast [2];
  int            mstall[2];
  int            mbub  [2];
  logic          acc   [2];
  int            cmax  [2] = '{15, 65535};

  int tests = 0;
  int fails = 0;

  function automatic logic m_ready(int d);
    if (d == 0) return msz[0] < 2;
    return (msz[1] == 0) || out_ready;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      msz[d] = 0; mlast[d] = '0; mstall[d] = 0; mbub[d] = 0; acc[d] = 1'b0;
    end
  endtask

  task automatic m_edge();
    logic rdy, pp, ps;
    for (int d = 0; d < 2; d++) begin
      rdy = m_ready(d);
      pp  = (msz[d] > 0) && out_ready;
      ps  = in_valid && rdy && !flush;
      acc[d] = ps;
      if (msz[d] > 0 && !out_ready && mstall[d] < cmax[d]) mstall[d]++;
      if (flush && msz[d] > 0 && mbub[d] < cmax[d]) mbub[d]++;
      if (flush) msz[d] = 0;
      else begin
        if (pp) begin mq[d][0] = mq[d][1]; msz[d]--; end
        if (ps) begin mq[d][msz[d]] = '{c: in_ctrl, d: in_data}; msz[d]++; end
      end
      if (msz[d] > 0) mlast[d] = mq[d][0].d;
    end
  endtask

  function automatic logic [73:0] exp_vec(int d);
    logic [CW-1:0] c;
    c = (msz[d] > 0) ? mq[d][0].c : '0;
    return {msz[d] > 0, m_ready(d), c, mlast[d], 16'(mstall[d]), 16'(mbub[d])};
  endfunction

  function automatic logic [73:0] act_vec(int d);
    if (d == 0)
      return {a_out_valid, a_in_ready, a_out_ctrl, a_out_data, 12'd0, a_stall, 12'd0, a_bubble};
    return {b_out_valid, b_in_ready, b_out_ctrl, b_out_data, b_stall, b_bubble};
  endfunction

  task automatic tick();
    @(posedge Clk);
    if (!Rst) m_edge();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    #3;
    m_reset();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; idle_inputs(); out_ready = 1'b0;
    m_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (act_vec(d) !== exp_vec(d)) begin
        fails++; $display("FAIL reset dut%0d: got %h expected %h", d, act_vec(d), exp_vec(d));
      end
    end
    tick(); tick();
    tests++;
    if ({a_out_valid, a_in_ready, a_out_ctrl, a_out_data} !== {1'b0, 1'b1, 8'h00, 32'h0}) begin
      fails++; $display("FAIL reset_hold: got v=%b r=%b c=%h d=%h expected 0 1 00 0",
                        a_out_valid, a_in_ready, a_out_ctrl, a_out_data);
    end
    Rst = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = (k <= 3); in_ctrl = CW'(k); in_data = $urandom;
      #1;
      if (k > 1) begin
        tests++;
        if (a_out_ctrl !== CW'(k - 1) || b_out_ctrl !== CW'(k - 1) || !a_out_valid || !b_out_valid) begin
          fails++; $display("FAIL stream_order: got a=%h b=%h expected %h", a_out_ctrl, b_out_ctrl, k - 1);
        end
      end
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (act_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL stream dut%0d: got %h expected %h", d, act_vec(d), exp_vec(d));
        end
      end
      tick();
    end
    idle_inputs();
    #1;
    tests++;
    if (a_out_valid !== 1'b0 || a_stall !== 4'd0 || b_stall !== 16'd0) begin
      fails++; $display("FAIL stream_end: got v=%b stall=%0d/%0d expected 0 0/0", a_out_valid, a_stall, b_stall);
    end
  endtask

  task automatic test_back_pressure();
    logic [CW-1:0] up [3] = '{8'h10, 8'h11, 8'h12};
    logic [CW-1:0] seen [$];
    int idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 3); in_ctrl = (idx < 3) ? up[idx] : '0; in_data = $urandom;
      out_ready = (c >= 4);
      #1;
      if (c == 2 || c == 3) begin
        tests++;
        if (a_in_ready !== 1'b0 || a_out_ctrl !== 8'h10) begin
          fails++; $display("FAIL bp_hold: got ready=%b ctrl=%h expected 0 10", a_in_ready, a_out_ctrl);
        end
      end
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (act_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL back_pressure dut%0d: got %h expected %h", d, act_vec(d), exp_vec(d));
        end
      end
      if (a_out_valid && out_ready) seen.push_back(a_out_ctrl);
      tick();
      if (acc[0]) idx++;
    end
    tests++;
    if (seen.size() != 3 || seen[0] !== 8'h10 || seen[1] !== 8'h11 || seen[2] !== 8'h12) begin
      fails++; $display("FAIL bp_order: got %0d beats first=%h expected 10 11 12", seen.size(),
                        seen.size() > 0 ? seen[0] : 8'hxx);
    end
    tests++;
    if (a_stall !== 4'd3) begin
      fails++; $display("FAIL bp_stall: got %0d expected 3", a_stall);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [DW-1:0] d1;
    do_reset();
    out_ready = 1'b0;
    d1 = $urandom;
    in_valid = 1'b1; in_ctrl = 8'h21; in_data = d1; #1; tick();
    in_ctrl = 8'h22; in_data = $urandom; #1; tick();
    in_ctrl = 8'h77; in_data = $urandom; flush = 1'b1; #1; tick();
    idle_inputs();
    #1;
    tests++;
    if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_out_data !== d1 || a_bubble !== 4'd1) begin
      fails++; $display("FAIL flush_skid: got v=%b c=%h d=%h bub=%0d expected 0 00 %h 1",
                        a_out_valid, a_out_ctrl, a_out_data, a_bubble, d1);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests++;
      if (a_out_valid !== 1'b0 || a_out_ctrl === 8'h77 || b_out_ctrl === 8'h77) begin
        fails++; $display("FAIL flush_drop: got v=%b a=%h b=%h expected no beat", a_out_valid, a_out_ctrl, b_out_ctrl);
      end
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (act_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL flush dut%0d: got %h expected %h", d, act_vec(d), exp_vec(d));
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h40; in_data = $urandom; #1; tick();
    idle_inputs();
    for (int c = 0; c < 20; c++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (act_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL saturation dut%0d: got %h expected %h", d, act_vec(d), exp_vec(d));
        end
      end
      tick();
    end
    tests++;
    if (a_stall !== 4'd15 || b_stall !== 16'd20) begin
      fails++; $display("FAIL stall_sat: got %0d/%0d expected 15/20", a_stall, b_stall);
    end
    tick();
    tests++;
    if (a_stall !== 4'd15) begin
      fails++; $display("FAIL stall_sat_hold: got %0d expected 15", a_stall);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h51; in_data = $urandom; #1; tick();
    in_ctrl = 8'h52; #1; tick();
    idle_inputs();
    #2;
    Rst = 1'b1;
    #1;
    tests++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_ctrl !== 8'h00 || a_stall !== 4'd0) begin
      fails++; $display("FAIL async_reset: got v=%b r=%b c=%h stall=%0d expected 0 1 00 0",
                        a_out_valid, a_in_ready, a_out_ctrl, a_stall);
    end
    m_reset();
    #1;
    Rst = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 32'hCAFE_0001;
    #1;
    tick();
    idle_inputs();
    #1;
    tests++;
    if (a_out_valid !== 1'b1 || a_out_ctrl !== 8'h5A || a_out_data !== 32'hCAFE_0001) begin
      fails++; $display("FAIL post_reset_push: got v=%b c=%h d=%h expected 1 5a cafe0001",
                        a_out_valid, a_out_ctrl, a_out_data);
    end
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (act_vec(d) !== exp_vec(d)) begin
        fails++; $display("FAIL async_reset dut%0d: got %h expected %h", d, act_vec(d), exp_vec(d));
      end
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_no_skid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h31; in_data = $urandom; #1; tick();
    in_ctrl = 8'h32; in_data = $urandom;
    #1;
    tests++;
    if (b_in_ready !== 1'b0) begin
      fails++; $display("FAIL noskid_block: got in_ready=%b expected 0", b_in_ready);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (b_in_ready !== 1'b1 || b_out_ctrl !== 8'h31) begin
      fails++; $display("FAIL noskid_comb: got in_ready=%b ctrl=%h expected 1 31", b_in_ready, b_out_ctrl);
    end
    tick();
    idle_inputs();
    #1;
    tests++;
    if (b_out_valid !== 1'b1 || b_out_ctrl !== 8'h32) begin
      fails++; $display("FAIL noskid_pushpop: got v=%b ctrl=%h expected 1 32", b_out_valid, b_out_ctrl);
    end
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (act_vec(d) !== exp_vec(d)) begin
        fails++; $display("FAIL no_skid dut%0d: got %h expected %h", d, act_vec(d), exp_vec(d));
      end
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_ctrl   = CW'($urandom);
      in_data   = $urandom;
      flush     = ($urandom_range(11) == 0);
      out_ready = (c % 100 > 70) ? 1'b0 : ($urandom_range(2) != 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (act_vec(d) !== exp_vec(d)) begin
          fails++; $display("FAIL random c%0d dut%0d: got %h expected %h", c, d, act_vec(d), exp_vec(d));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_saturation();
    test_async_reset();
    test_no_skid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register, the successor to the fixed ID→EX latch. It carries a clearable control field and a non-clearable data field between any two CPU stages. It uses a valid/ready handshake with an optional one-entry skid buffer, so that `in_ready` is registered. It also supports synchronous flush (bubble insertion) and saturating stall/bubble performance counters. It sits between IF/ID, ID/EX, EX/MEM and MEM/WB in place of the hand-written stage latches.

## Interface
- `DATA_W`, 128, width of the data payload (busA, busB, imm, PC…); never cleared by flush.
- `CTRL_W`, 48, width of the control payload (RegWr, MemWr, ALUctr, rd…); forced to `CTRL_RST` on reset, flush or empty.
- `CTRL_RST`, `'0`, bubble value of the control field; must encode a NOP (no register or memory write).
- `SKID`, 1, 1 = two-entry (main + skid) with registered `in_ready`; 0 = single entry with combinational `in_ready`.
- `CNT_W`, 16, width of the performance counters.

- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  reset; asynchronous, active-high (already decided).
- `in_valid`  in  1  upstream has a beat.
- `in_ready`  out  1  stage can accept a beat.
- `in_ctrl`  in  CTRL_W  upstream control.
- `in_data`  in  DATA_W  upstream data.
- `flush`  in  1  synchronous kill of all held beats (branch taken / load-use hazard).
- `out_valid`  out  1  main entry holds a beat.
- `out_ready`  in  1  downstream accepts.
- `out_ctrl`  out  CTRL_W  main-entry control; `CTRL_RST` whenever `out_valid`=0.
- `out_data`  out  DATA_W  main-entry data; holds its last value when empty.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.
- `bubble_cnt`  out  CNT_W  flush cycles that killed at least one valid beat, saturating.

## Operation
- Reset: state EMPTY; `out_valid`=0; `in_ready`=1 when `SKID`=1; `out_ctrl`=`CTRL_RST`; `out_data`=0; skid entry cleared; both counters=0.
- Definitions: push = `in_valid && in_ready && !flush`; pop = `out_valid && out_ready`.
- States (`SKID`=1): EMPTY, FULL (main valid), SKID (main + skid valid).
  - EMPTY: push → FULL.
  - FULL: push && !pop → SKID. Push && pop → FULL with main ← input. Pop only → EMPTY.
  - SKID: pop → FULL with main ← skid entry. No push is possible, because `in_ready`=0.
- `SKID`=0: the states are EMPTY/FULL only, and `in_ready` = `!out_valid || out_ready`.
- Ordering: beats leave in arrival order. A skid beat always precedes any later input.
- Flush (any state): next state EMPTY; main and skid control ← `CTRL_RST`; data fields are retained. Flush beats a simultaneous push, and that input beat is dropped. A pop in the same cycle still completes downstream.
- `bubble_cnt` increments when flush=1 and (main or skid) is valid.
- `stall_cnt` increments each cycle with `out_valid && !out_ready`.
- Both counters saturate at all-ones and clear only on `Rst`.
- When main empties without a refill, `out_ctrl` ← `CTRL_RST` on that edge.

## Timing
- Latency: a beat pushed at edge N appears on `out_*` after edge N, with `out_valid`=1 in cycle N+1.
- Throughput: one beat per cycle when `out_ready` is held at 1, in both `SKID` modes.
- `in_ready` (`SKID`=1) is a flop: it falls on the edge entering SKID and rises on the edge leaving it.
- All outputs are registered except `in_ready` when `SKID`=0.
- `Rst` asserted mid-transfer: outputs take their reset values immediately, without waiting for `Clk`. Held beats are lost. The first push is accepted on the first edge after deassertion.
- `flush` and `Rst` both asserted: `Rst` dominates. Counters clear.

## Structure
- Shared package `pipe_pkg`: the state enum (EMPTY/FULL/SKID) and the stage control-field bundles, with their NOP constants used as `CTRL_RST`.
- Sub-module `pipe_sat_counter` (parameter `CNT_W`; ports `Clk`, `Rst`, `inc`, `count`) is instantiated twice.

## Test plan
- Reset then stream: `out_ready`=1; push control 0x1, 0x2, 0x3 on consecutive cycles → `out_ctrl` shows 0x1, 0x2, 0x3 in cycles 1–3, with no gaps and `stall_cnt`=0.
- Back-pressure (`SKID`=1): `out_ready`=0 while pushing 0x10, 0x11, 0x12 → 0x10 held in main, 0x11 in skid, `in_ready`=0, and 0x12 held by upstream. Releasing `out_ready` → output order 0x10, 0x11, 0x12; `stall_cnt` equals the number of held cycles.
- Flush in SKID state with a simultaneous push → next cycle `out_valid`=0, `out_ctrl`=`CTRL_RST`, `out_data` unchanged, `bubble_cnt`=1, and the pushed beat never appears.
- Counter saturation: `CNT_W`=4, hold `out_ready`=0 for 20 cycles → `stall_cnt`=15 and stays 15.
- Async reset mid-SKID: assert `Rst` between edges → `out_valid`=0 and `in_ready`=1 before the next edge. After release, a single push appears one cycle later.
- `SKID`=0: `out_valid`=1, `out_ready`=0 → `in_ready`=0 combinationally. Raising `out_ready` in the same cycle → `in_ready`=1, and push and pop both complete.
